// File: rtl/temporizador_pwm_if.sv
// Control/status bundle of the PWM timer: run control, shadow-load handshake
// and the counter/PWM observation outputs.
interface temporizador_pwm_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
);
    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      periodo;
    logic [WIDTH-1:0]      ciclo;
    logic                  cargar;
    logic                  cargar_ack;
    logic [WIDTH-1:0]      cuenta;
    logic                  pwm;
    logic                  fin_periodo;

    modport master (
        output en, prescale, periodo, ciclo, cargar,
        input  cargar_ack, cuenta, pwm, fin_periodo
    );
    modport slave (
        input  en, prescale, periodo, ciclo, cargar,
        output cargar_ack, cuenta, pwm, fin_periodo
    );
endinterface

// File: rtl/temporizador_pwm.sv
// Prescaled periodic timer with glitch-free PWM: period/duty go through shadow
// registers that only become active at a period wrap while running.
module temporizador_pwm #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    temporizador_pwm_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nx;
    logic [PRESCALE_W-1:0] presc;
    logic [WIDTH-1:0]      cuenta;
    logic [WIDTH-1:0]      per_act, duty_act;
    logic [WIDTH-1:0]      per_pend, duty_pend;
    logic                  pend;
    logic                  fin, ack;
    logic                  tick, wrap, pwm;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en)  state_nx = RUN;
            RUN:     if (!bus.en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A tick on the edge that leaves RUN is dropped: the stop wins.
    always_comb begin
        tick = (state == RUN) && bus.en && (presc == bus.prescale);
        wrap = tick && (cuenta == per_act);
        pwm  = (state == RUN) && (cuenta < duty_act);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            cuenta    <= '0;
            per_act   <= '0;
            duty_act  <= '0;
            per_pend  <= '0;
            duty_pend <= '0;
            pend      <= 1'b0;
            fin       <= 1'b0;
            ack       <= 1'b0;
        end else begin
            fin <= 1'b0;
            ack <= 1'b0;
            if (state == RUN && bus.en) begin
                if (tick) begin
                    presc <= '0;
                    if (wrap) begin
                        cuenta <= '0;
                        fin    <= 1'b1;
                        if (pend) begin
                            per_act  <= per_pend;
                            duty_act <= duty_pend;
                            ack      <= 1'b1;
                        end
                    end else begin
                        cuenta <= cuenta + 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
                // A load landing on the wrap edge is held for the next boundary.
                if (bus.cargar) begin
                    per_pend  <= bus.periodo;
                    duty_pend <= bus.ciclo;
                    pend      <= 1'b1;
                end else if (wrap) begin
                    pend      <= 1'b0;
                end
            end else begin
                cuenta <= '0;
                presc  <= '0;
                pend   <= 1'b0;
                if (state == IDLE && bus.cargar) begin
                    per_act  <= bus.periodo;
                    duty_act <= bus.ciclo;
                    ack      <= 1'b1;
                end
            end
        end
    end

    assign bus.cuenta      = cuenta;
    assign bus.pwm         = pwm;
    assign bus.fin_periodo = fin;
    assign bus.cargar_ack  = ack;
endmodule

// File: tb/tb_temporizador_pwm.sv
// Self-checking bench for temporizador_pwm: per-cycle vectors, expected
// outputs queued on drive and compared after the clock edge.
module tb_temporizador_pwm;
    logic clk = 1'b0;
    logic rst;

    temporizador_pwm_if #(.WIDTH(8), .PRESCALE_W(8)) bus ();

    temporizador_pwm #(.WIDTH(8), .PRESCALE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] ps;
        logic [7:0] per;
        logic [7:0] duty;
        logic       carg;
        logic [7:0] c;
        logic       p;
        logic       f;
        logic       a;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        logic       p;
        logic       f;
        logic       a;
    } exp_t;

    exp_t  sb[$];
    vec_t  tbl[$];
    int    checks = 0;
    int    errors = 0;

    function automatic vec_t mk(input logic r, input logic e, input int ps,
                                input int per, input int duty, input logic cg,
                                input int c, input logic p, input logic f,
                                input logic a);
        vec_t v;
        v.rst = r; v.en = e; v.ps = 8'(ps); v.per = 8'(per); v.duty = 8'(duty);
        v.carg = cg; v.c = 8'(c); v.p = p; v.f = f; v.a = a;
        return v;
    endfunction

    // Reset, load in IDLE, then n running cycles with closed-form expectations.
    task automatic add_run(input int per, input int duty, input int ps, input int n);
        tbl.push_back(mk(1, 0, ps, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, ps, per, duty, 1, 0, 0, 0, 1));
        for (int k = 0; k < n; k++) begin
            int c;
            c = (k / (ps + 1)) % (per + 1);
            tbl.push_back(mk(0, 1, ps, 0, 0, 0, c, c < duty,
                             (k > 0) && (k % ((ps + 1) * (per + 1)) == 0), 0));
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input vec_t v, input string tag);
        exp_t e;
        rst         = v.rst;
        bus.en      = v.en;
        bus.prescale = v.ps;
        bus.periodo = v.per;
        bus.ciclo   = v.duty;
        bus.cargar  = v.carg;
        sb.push_back('{c: v.c, p: v.p, f: v.f, a: v.a});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, " cuenta"},      bus.cuenta,      e.c);
            chk({tag, " pwm"},         bus.pwm,         e.p);
            chk({tag, " fin_periodo"}, bus.fin_periodo, e.f);
            chk({tag, " cargar_ack"},  bus.cargar_ack,  e.a);
        end
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.prescale = '0;
        bus.periodo = '0; bus.ciclo = '0; bus.cargar = 1'b0;

        add_run(4, 2, 0, 12);    // basic 5-cycle period
        add_run(4, 2, 2, 33);    // prescaled: 15-cycle period
        add_run(4, 0, 0, 8);     // duty 0
        add_run(4, 255, 0, 8);   // duty beyond period
        add_run(0, 1, 0, 5);     // period 0
        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], "table");

        // Reload mid-period: takes effect at wrap with ack+fin together
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reload");
        cyc(mk(0, 0, 0, 4, 2, 1, 0, 0, 0, 1), "reload");
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "reload");
        cyc(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), "reload");
        for (int k = 2; k <= 16; k++) begin
            if (k <= 4)
                cyc(mk(0, 1, 0, 9, 5, k == 2, k, k < 2, 0, 0), "reload");
            else
                cyc(mk(0, 1, 0, 9, 5, 0, (k - 5) % 10, ((k - 5) % 10) < 5,
                       (k == 5) || (k == 15), k == 5), "reload");
        end

        // Two loads in one period: last wins, single ack
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "dbl");
        cyc(mk(0, 0, 0, 4, 2, 1, 0, 0, 0, 1), "dbl");
        for (int k = 0; k <= 13; k++) begin
            int per, duty, c;
            per  = (k == 1) ? 3 : 6;
            duty = (k == 1) ? 1 : 3;
            c    = (k < 5) ? k : (k - 5) % 7;
            cyc(mk(0, 1, 0, per, duty, (k == 1) || (k == 3), c,
                   (k < 5) ? (c < 2) : (c < 3), (k == 5) || (k == 12), k == 5), "dbl");
        end

        // Stop at cuenta=3
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "stop");
        cyc(mk(0, 0, 0, 4, 2, 1, 0, 0, 0, 1), "stop");
        for (int k = 0; k <= 3; k++) cyc(mk(0, 1, 0, 0, 0, 0, k, k < 2, 0, 0), "stop");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "stop");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "stop");

        // Reset with a load pending: discarded, active period returns to 0
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "rstpend");
        cyc(mk(0, 1, 0, 9, 5, 1, 1, 1, 0, 0), "rstpend");
        cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rstpend");
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rstpend");
        for (int k = 0; k <= 3; k++) cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, k > 0, 0), "rstpend");
        for (int k = 0; k <= 6; k++) cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "rstpend");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
